// File: rtl/serial_src_pkg.sv
// Shared types and width helpers for the serial bit source.
package serial_src_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  // Bit counter width: indexes 0 .. data_w-1
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w);
  endfunction

  // Level needs one extra bit so that a full FIFO (level == depth) is representable
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_DATA_W);
  localparam int DEF_LVL_W = level_width(DEF_DEPTH);

endpackage

// File: rtl/serial_src_fifo.sv
// Synchronous word FIFO with level count and synchronous flush.
module serial_src_fifo
  import serial_src_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                flush,
  input  logic                                push,
  input  logic [DATA_W-1:0]                   wdata,
  input  logic                                pop,
  output logic [DATA_W-1:0]                   rdata,
  output logic                                full,
  output logic                                empty,
  output logic [level_width(DEPTH)-1:0]       level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign push_ok_s = push && !full && !flush;
  assign pop_ok_s  = pop && !empty && !flush;
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage array; contents are don't-care while the level says empty
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/serial_bit_source.sv
// Buffers parallel words and serializes them one bit per clock, with no gap
// between back-to-back words and a fixed idle level otherwise.
module serial_bit_source
  import serial_src_pkg::*;
#(
  parameter int   DATA_W    = DEF_DATA_W,
  parameter int   DEPTH     = DEF_DEPTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      d_out,
  output logic                      d_valid,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e            state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
  logic [DATA_W-1:0] sr_r, sr_nx_s;
  logic              d_out_r, d_out_nx_s;
  logic              d_valid_r, d_valid_nx_s;
  logic              load_s, shift_s, pop_s, push_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [DATA_W-1:0] head_s;

  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign in_ready = !fifo_full_s && !flush;
  assign push_s   = in_valid && in_ready;
  assign busy     = (state_r == SHIFT) || !fifo_empty_s;
  assign d_out    = d_out_r;
  assign d_valid  = d_valid_r;

  serial_src_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push_s),
    .wdata   (in_data),
    .pop     (pop_s),
    .rdata   (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  // Next-state, shift-register and output-bit decode
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    sr_nx_s      = sr_r;
    d_out_nx_s   = IDLE_BIT;
    d_valid_nx_s = 1'b0;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    pop_s        = 1'b0;
    if (flush) begin
      state_nx_s = IDLE;
      cnt_nx_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            load_s = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end
        SHIFT: begin
          if (cnt_r != CNT_LAST) begin
            shift_s = 1'b1;
          end else if (!fifo_empty_s) begin
            load_s = 1'b1;
          end else begin
            state_nx_s = IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
          end
        end
        default: begin
          state_nx_s = IDLE;
          cnt_nx_s   = {CNT_W{1'b0}};
        end
      endcase
    end
    // The register holds the bits still to come; d_out carries the current one
    if (load_s) begin
      pop_s        = 1'b1;
      state_nx_s   = SHIFT;
      cnt_nx_s     = {CNT_W{1'b0}};
      d_out_nx_s   = lead_bit(head_s);
      sr_nx_s      = advance(head_s);
      d_valid_nx_s = 1'b1;
    end else if (shift_s) begin
      cnt_nx_s     = cnt_r + CNT_W'(1);
      d_out_nx_s   = lead_bit(sr_r);
      sr_nx_s      = advance(sr_r);
      d_valid_nx_s = 1'b1;
    end else begin
      sr_nx_s = sr_r;
    end
  end

  // State, counter, shift register and registered serial outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      sr_r      <= {DATA_W{1'b0}};
      d_out_r   <= IDLE_BIT;
      d_valid_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      sr_r      <= sr_nx_s;
      d_out_r   <= d_out_nx_s;
      d_valid_r <= d_valid_nx_s;
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Self-checking bench for serial_bit_source: directed table, corner sequences
// and randomized traffic against a word/bit-queue reference model.
module tb_serial_bit_source;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;
  logic       in_ready, d_out, d_valid, busy;
  logic [2:0] fifo_level;
  logic       b_in_ready, b_d_out, b_d_valid, b_busy;
  logic [2:0] b_fifo_level;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_bit_source #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .d_out(d_out), .d_valid(d_valid),
    .busy(busy), .fifo_level(fifo_level)
  );

  serial_bit_source #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .flush(flush), .d_out(b_d_out), .d_valid(b_d_valid),
    .busy(b_busy), .fifo_level(b_fifo_level)
  );

  // Reference model: queue of buffered words plus queue of bits still to emit
  logic [7:0] m_fifo [$];
  logic       m_bits [$];
  logic       m_dout, m_dv;
  bit         primed = 1'b0;

  logic       neg_ready;
  logic [2:0] neg_level;
  logic       obs_dout, obs_dv, obs_dout_b, obs_dv_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_edge(input logic rn, input logic fl, input logic v, input logic [7:0] d);
    logic       push;
    logic [7:0] w;
    if (!rn || fl) begin
      m_fifo.delete();
      m_bits.delete();
      m_dout = 1'b0;
      m_dv   = 1'b0;
    end else begin
      push = v && (m_fifo.size() < 4);
      if (m_bits.size() > 0) begin
        m_dout = m_bits.pop_front();
        m_dv   = 1'b1;
      end else if (m_fifo.size() > 0) begin
        w = m_fifo.pop_front();
        for (int i = 7; i >= 0; i--) m_bits.push_back(w[i]);
        m_dout = m_bits.pop_front();
        m_dv   = 1'b1;
      end else begin
        m_dout = 1'b0;
        m_dv   = 1'b0;
      end
      if (push) m_fifo.push_back(d);
    end
  endtask

  // One clock: drive, check in_ready mid-cycle, step the model, check outputs after the edge
  task automatic tick(input logic rn, input logic fl, input logic v, input logic [7:0] d);
    reset_n = rn; flush = fl; in_valid = v; in_data = d;
    @(negedge clk);
    neg_ready = in_ready;
    neg_level = fifo_level;
    if (primed) chk("in_ready", in_ready, (m_fifo.size() < 4) && !fl);
    model_edge(rn, fl, v, d);
    @(posedge clk);
    #1;
    obs_dout = d_out; obs_dv = d_valid; obs_dout_b = b_d_out; obs_dv_b = b_d_valid;
    if (primed || !rn) begin
      chk("d_out", d_out, m_dout);
      chk("d_valid", d_valid, m_dv);
      chk("fifo_level", fifo_level, m_fifo.size());
      chk("busy", busy, m_dv || (m_fifo.size() > 0));
    end
    if (!rn) primed = 1'b1;
  endtask

  typedef struct {
    logic rn, v;
    logic [7:0] d;
    logic e_dout, e_dv, e_busy, e_ready;
    logic [2:0] e_lvl;
  } vec_t;

  vec_t tbl [13];

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // Capture 8 cycles of serial output and assemble a word from the chosen instance
  task automatic capture_word(input bit lsb_inst, output logic [7:0] w, output int nv);
    w = 8'h00; nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      if (lsb_inst) begin
        w[i] = obs_dout_b;
        nv += int'(obs_dv_b);
      end else begin
        w = {w[6:0], obs_dout};
        nv += int'(obs_dv);
      end
    end
  endtask

  initial begin
    logic [7:0]  w, fw [7];
    logic [23:0] stream, mask;
    logic [3:0]  hist;
    int          nv, acc, idx, first_v, last_v, nbits;
    bit          seen;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // Reset with in_valid high, then a single 8'hA5 word
    for (int i = 0; i < 13; i++) begin
      tbl[i] = '{rn: 1'b1, v: 1'b0, d: 8'h00, e_dout: 1'b0, e_dv: 1'b0,
                 e_busy: 1'b0, e_ready: 1'b1, e_lvl: 3'd0};
    end
    for (int i = 0; i < 3; i++) begin
      tbl[i].rn = 1'b0; tbl[i].v = 1'b1; tbl[i].d = 8'h33;
    end
    tbl[3].v = 1'b1; tbl[3].d = 8'hA5; tbl[3].e_busy = 1'b1; tbl[3].e_lvl = 3'd1;
    w = 8'hA5;
    for (int i = 4; i < 12; i++) begin
      tbl[i].e_dout = w[11 - i]; tbl[i].e_dv = 1'b1; tbl[i].e_busy = 1'b1;
    end
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].rn, 1'b0, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_dout", i), d_out, tbl[i].e_dout);
      chk($sformatf("tbl%0d_dvalid", i), d_valid, tbl[i].e_dv);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_ready);
    end

    // Back-to-back AA, 0F, 50 with a 1010 scan over the stream
    tick(1'b1, 1'b0, 1'b1, 8'hAA);
    stream = 24'h0; mask = 24'h0; hist = 4'h0; nbits = 0; first_v = -1; last_v = -1;
    for (int k = 0; k < 28; k++) begin
      if (k == 0)      tick(1'b1, 1'b0, 1'b1, 8'h0F);
      else if (k == 1) tick(1'b1, 1'b0, 1'b1, 8'h50);
      else             tick(1'b1, 1'b0, 1'b0, 8'h00);
      if (obs_dv) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        stream = {stream[22:0], obs_dout};
        hist   = {hist[2:0], obs_dout};
        if (hist == 4'b1010 && nbits >= 3 && nbits < 24) mask[nbits] = 1'b1;
        nbits++;
      end
    end
    chk("b2b_count", nbits, 24);
    chk("b2b_first", first_v, 0);
    chk("b2b_contig", last_v - first_v + 1, 24);
    chk("b2b_stream", stream, 24'hAA0F50);
    chk("b2b_1010_pos", mask, 24'h1400A8);

    // Full FIFO: six words offered while the shifter is busy
    fw[0] = 8'hC3; fw[1] = 8'h11; fw[2] = 8'h22; fw[3] = 8'h33;
    fw[4] = 8'h44; fw[5] = 8'h55; fw[6] = 8'h66;
    tick(1'b1, 1'b0, 1'b1, fw[0]);
    idx = 1; acc = 0;
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, 1'b0, 1'b1, fw[idx]);
      if (neg_ready && idx < 6) begin idx++; acc++; end
    end
    chk("full_accepts", acc, 4);
    chk("full_ready_low", in_ready, 1'b0);
    chk("full_level", fifo_level, 3'd4);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick(1'b1, 1'b0, idx < 7, (idx < 7) ? fw[idx] : 8'h00);
      if (neg_ready && !seen) begin
        seen = 1'b1;
        chk("full_reassert_level", neg_level, 3'd3);
      end
      if (neg_ready && idx < 7) idx++;
    end
    chk("full_reassert_seen", seen, 1'b1);
    chk("full_all_accepted", idx, 7);
    chk("full_drained", busy, 1'b0);

    // Flush (pass 0) or reset (pass 1) on bit 3 of 8'hFF with two words queued
    for (int pass = 0; pass < 2; pass++) begin
      tick(1'b1, 1'b0, 1'b1, 8'hFF);
      tick(1'b1, 1'b0, 1'b1, 8'h11);
      tick(1'b1, 1'b0, 1'b1, 8'h22);
      idle_ticks(2);
      chk($sformatf("abort%0d_pre_level", pass), fifo_level, 3'd2);
      chk($sformatf("abort%0d_pre_dv", pass), d_valid, 1'b1);
      if (pass == 0) tick(1'b1, 1'b1, 1'b0, 8'h00);
      else           tick(1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("abort%0d_dv", pass), d_valid, 1'b0);
      chk($sformatf("abort%0d_dout", pass), d_out, 1'b0);
      chk($sformatf("abort%0d_level", pass), fifo_level, 3'd0);
      tick(1'b1, 1'b0, 1'b1, 8'h81);
      capture_word(1'b0, w, nv);
      chk($sformatf("abort%0d_word", pass), w, 8'h81);
      chk($sformatf("abort%0d_nvalid", pass), nv, 8);
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      chk($sformatf("abort%0d_idle_dv", pass), d_valid, 1'b0);
      chk($sformatf("abort%0d_idle_busy", pass), busy, 1'b0);
    end

    // LSB-first instance: 8'h05 must come out 1,0,1,0,0,0,0,0
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b1, 8'h05);
    capture_word(1'b1, w, nv);
    chk("lsb_word", w, 8'h05);
    chk("lsb_nvalid", nv, 8);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("lsb_idle_dv", b_d_valid, 1'b0);
    chk("lsb_idle_dout", b_d_out, 1'b0);

    // Random traffic with occasional flush and reset, checked by the model every cycle
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 99) < 55, 8'($urandom));
    end
    idle_ticks(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Upstream stage for the 1010 sequence detector. Accepts parallel words through a valid/ready handshake, buffers them in a small FIFO, and serializes them one bit per clock onto a single line that drives the detector's serial data input. Back-to-back words stream with no idle gap. When no data is available, the line holds a fixed idle level.

## Interface
- DATA_W, 8, width of each parallel word (≥2)
- DEPTH, 4, FIFO depth in words (power of 2, ≥2)
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
- IDLE_BIT, 1'b0, value driven on d_out when no data bit is presented

- clk  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  reset; synchronous, active-low
- in_data  in  DATA_W  parallel word
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept a word
- flush  in  1  synchronous abort: empties the FIFO and drops the current word
- d_out  out  1  serial bit (registered), feeds the detector's d_in
- d_valid  out  1  d_out carries a data bit this cycle
- busy  out  1  shifter is in SHIFT, or the FIFO is non-empty
- fifo_level  out  $clog2(DEPTH)+1  words currently in the FIFO

## Operation
- **Reset** (reset_n low at a rising edge): FIFO empty, state IDLE, bit counter 0, d_out=IDLE_BIT, d_valid=0, busy=0, fifo_level=0, in_ready=1.
- **Write**: a word is accepted when in_valid && in_ready.
  - in_ready = (fifo_level < DEPTH) && !flush.
  - A pop in the same cycle does not raise in_ready when the FIFO is full.
- **FSM states**: IDLE, SHIFT.
  - IDLE, FIFO non-empty: pop the head into the shift register, drive the first bit on d_out, set d_valid=1, counter=0, go to SHIFT.
  - SHIFT, counter < DATA_W-1: shift, drive the next bit, counter+1.
  - SHIFT, counter == DATA_W-1, FIFO non-empty: pop and load the next word immediately (no gap), counter=0.
  - SHIFT, counter == DATA_W-1, FIFO empty: go to IDLE, d_out=IDLE_BIT, d_valid=0.
- **Bit order**: MSB_FIRST=1 emits bit DATA_W-1 down to bit 0; MSB_FIRST=0 emits bit 0 up to bit DATA_W-1.
- **fifo_level**: +1 on push, −1 on pop, unchanged on a simultaneous push and pop. It never exceeds DATA_W-independent DEPTH and never underflows.
- **Pointers**: wrap modulo DEPTH. Full and empty are distinguished by the extra level bit.
- **Flush**: has priority over push and pop. At the next edge the FIFO is emptied, the state goes to IDLE, d_out=IDLE_BIT, d_valid=0, and the partial word is discarded.
- **Reset mid-word**: same result as flush, plus all counters are cleared. No partial bits are emitted after reset.

## Timing
- Latency: a word pushed at edge N into an empty FIFO with the shifter in IDLE has its first bit on d_out after edge N+1. Its last bit appears after edge N+DATA_W.
- Each bit holds for exactly one cycle. d_valid is continuously high across back-to-back words.
- Throughput: one word per DATA_W cycles. Sustained streaming requires the FIFO to stay non-empty at each word boundary.
- in_ready falls in the cycle after the push that fills the FIFO.

## Structure
- **Shared package** `serial_src_pkg`:
  - state enum {IDLE, SHIFT}
  - localparams for the counter width ($clog2(DATA_W)) and level width
- **Sub-module** `serial_src_fifo`: synchronous FIFO with push/pop/full/empty/level and sync flush.
- **Top level**: FSM, shift register, bit counter, and the output register.

## Test plan
- **Reset**: hold reset_n low for 3 cycles with in_valid=1 → in_ready=1, d_out=0, d_valid=0, fifo_level=0, no word accepted.
- **Single word**: push 8'hA5, MSB_FIRST=1 → starting one cycle after the push, d_out = 1,0,1,0,0,1,0,1 with d_valid high for exactly 8 cycles, then d_out=0 and busy=0.
- **Back-to-back**: push 8'hAA, 8'h0F, 8'h50 on consecutive cycles → 24 contiguous d_valid cycles with the correct bit stream and no gap at word boundaries. A downstream detector sees 1010 at the expected bit positions.
- **Full FIFO**: while the shifter is busy, offer 6 words continuously → only 4 are accepted into the FIFO; in_ready is low while fifo_level=4 and reasserts on the next pop. No word is lost or duplicated.
- **Flush and reset mid-word**:
  - Assert flush on bit 3 of 8'hFF with 2 words queued → next cycle d_valid=0, d_out=0, fifo_level=0; a subsequent push of 8'h81 emits cleanly.
  - Repeat the scenario using reset_n instead of flush → same result.
- **LSB first**: MSB_FIRST=0, push 8'h05 → d_out = 1,0,1,0,0,0,0,0.
